// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Purpose:
//   Steps an LED pattern once per rising edge of a slow square wave coming
//   from the clock divider. The square wave is treated as ordinary data in the
//   clk domain. A debounced, active-low push-button cycles through four modes:
//   COUNT (binary up-count), WALK (rotating single LED), BOUNCE (single LED
//   travelling end to end) and BLINK (all on / all off).
//
// Ports:
//   clk          in   system clock, the only clock of the block
//   rst_n        in   synchronous active-low reset, sampled on posedge clk
//   tick_in      in   divided square wave, level signal in the clk domain
//   mode_btn     in   raw push-button, active-low, asynchronous to clk
//   led          out  LED_COUNT-bit LED drive, inverted when LED_ACTIVE_LOW=1
//   mode         out  current mode: 0 COUNT, 1 WALK, 2 BOUNCE, 3 BLINK
//   step_strobe  out  one-cycle pulse on every pattern advance
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int LED_COUNT       = 6,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit LED_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_in,
    input  logic                 mode_btn,
    output logic [LED_COUNT-1:0] led,
    output logic [1:0]           mode,
    output logic                 step_strobe
);

    localparam int W     = LED_COUNT;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [W-1:0] PAT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] PAT_ONE  = {{(W-1){1'b0}}, 1'b1};

    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_WALK   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Pattern loaded when a mode is entered.
    function automatic logic [W-1:0] mode_seed(input logic [1:0] m);
        logic [W-1:0] seed;
        case (m)
            MODE_COUNT:  seed = PAT_ZERO;
            MODE_WALK:   seed = PAT_ONE;
            MODE_BOUNCE: seed = PAT_ONE;
            MODE_BLINK:  seed = PAT_ZERO;
            default:     seed = PAT_ZERO;
        endcase
        return seed;
    endfunction

    // State registers
    logic             r_tick_q;
    logic             r_btn_meta;
    logic             r_btn_sync;
    logic             r_btn_stable;
    logic [CNT_W-1:0] r_db_cnt;
    logic [1:0]       r_mode;
    logic [W-1:0]     r_pattern;
    logic             r_dir;
    logic             r_step_strobe;

    // Next-state values and decode
    logic             w_tick_rise;
    logic             w_btn_differs;
    logic             w_db_done;
    logic             w_press;
    logic             w_btn_stable_nxt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [W-1:0]     w_step_pattern;
    logic             w_step_dir;
    logic [1:0]       w_mode_nxt;
    logic [W-1:0]     w_pattern_nxt;
    logic             w_dir_nxt;
    logic             w_step_strobe_nxt;

    // State register: all flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Capture the current tick level so a wave already high at release
            // is not mistaken for a rising edge.
            r_tick_q      <= tick_in;
            r_btn_meta    <= 1'b1;
            r_btn_sync    <= 1'b1;
            r_btn_stable  <= 1'b1;
            r_db_cnt      <= CNT_ZERO;
            r_mode        <= MODE_COUNT;
            r_pattern     <= PAT_ZERO;
            r_dir         <= DIR_UP;
            r_step_strobe <= 1'b0;
        end else begin
            r_tick_q      <= tick_in;
            r_btn_meta    <= mode_btn;
            r_btn_sync    <= r_btn_meta;
            r_btn_stable  <= w_btn_stable_nxt;
            r_db_cnt      <= w_db_cnt_nxt;
            r_mode        <= w_mode_nxt;
            r_pattern     <= w_pattern_nxt;
            r_dir         <= w_dir_nxt;
            r_step_strobe <= w_step_strobe_nxt;
        end
    end

    // Next-state logic: tick edge detect, debounce, per-mode step, mode change.
    always_comb begin
        w_tick_rise   = tick_in & ~r_tick_q;
        w_btn_differs = (r_btn_sync != r_btn_stable);
        w_db_done     = w_btn_differs && (r_db_cnt == CNT_LAST);
        // Only the 1->0 transition of the accepted level is a press.
        w_press       = w_db_done && r_btn_stable;

        // Debounce counter runs only while the synchronised level disagrees.
        w_btn_stable_nxt = r_btn_stable;
        w_db_cnt_nxt     = CNT_ZERO;
        if (w_db_done) begin
            w_btn_stable_nxt = r_btn_sync;
            w_db_cnt_nxt     = CNT_ZERO;
        end else if (w_btn_differs) begin
            w_db_cnt_nxt     = r_db_cnt + CNT_ONE;
        end else begin
            w_db_cnt_nxt     = CNT_ZERO;
        end

        // Candidate pattern for a step in the current mode.
        w_step_pattern = r_pattern;
        w_step_dir     = r_dir;
        case (r_mode)
            MODE_COUNT: begin
                w_step_pattern = r_pattern + PAT_ONE;
            end
            MODE_WALK: begin
                w_step_pattern = {r_pattern[W-2:0], r_pattern[W-1]};
            end
            MODE_BOUNCE: begin
                // Direction flips on the same edge the lit LED reaches an end,
                // so each end LED is lit for exactly one step.
                if (r_dir == DIR_UP) begin
                    w_step_pattern = {r_pattern[W-2:0], 1'b0};
                    w_step_dir     = w_step_pattern[W-1] ? DIR_DOWN : DIR_UP;
                end else begin
                    w_step_pattern = {1'b0, r_pattern[W-1:1]};
                    w_step_dir     = w_step_pattern[0] ? DIR_UP : DIR_DOWN;
                end
            end
            MODE_BLINK: begin
                w_step_pattern = ~r_pattern;
            end
            default: begin
                w_step_pattern = r_pattern;
                w_step_dir     = r_dir;
            end
        endcase

        // A press takes priority over a simultaneous tick edge; that step is lost.
        w_mode_nxt        = r_mode;
        w_pattern_nxt     = r_pattern;
        w_dir_nxt         = r_dir;
        w_step_strobe_nxt = 1'b0;
        if (w_press) begin
            w_mode_nxt        = r_mode + 2'd1;
            w_pattern_nxt     = mode_seed(r_mode + 2'd1);
            w_dir_nxt         = DIR_UP;
            w_step_strobe_nxt = 1'b0;
        end else if (w_tick_rise) begin
            w_pattern_nxt     = w_step_pattern;
            w_dir_nxt         = w_step_dir;
            w_step_strobe_nxt = 1'b1;
        end else begin
            w_step_strobe_nxt = 1'b0;
        end
    end

    // Output logic: LED polarity applied directly to the pattern register.
    always_comb begin
        if (LED_ACTIVE_LOW) begin
            led = ~r_pattern;
        end else begin
            led = r_pattern;
        end
        mode        = r_mode;
        step_strobe = r_step_strobe;
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_sequencer
//
// Purpose:
//   Directed self-checking bench for led_pattern_sequencer with LED_COUNT=6,
//   DEBOUNCE_CYCLES=4, LED_ACTIVE_LOW=1. Expected patterns are queued when a
//   tick is driven and popped when the step becomes visible.
// -----------------------------------------------------------------------------
module tb_led_pattern_sequencer;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick_in  = 1'b0;
    logic       mode_btn = 1'b1;
    logic [5:0] led;
    logic [1:0] mode;
    logic       step_strobe;

    int n_total    = 0;
    int n_pass     = 0;
    int n_fail     = 0;
    int strobe_cnt = 0;
    int c0;

    logic [5:0] sb_q[$];
    logic [5:0] bounce_tbl[12] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10,
                                   6'h08, 6'h04, 6'h02, 6'h01, 6'h02, 6'h04};
    logic [5:0] walk_tbl[6]   = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};

    led_pattern_sequencer #(
        .LED_COUNT       (6),
        .DEBOUNCE_CYCLES (4),
        .LED_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .mode_btn    (mode_btn),
        .led         (led),
        .mode        (mode),
        .step_strobe (step_strobe)
    );

    // 10 ns clock: posedges at 5, 15, ...; negedges at 10, 20, ...
    always #5 clk = ~clk;

    // Strobe counter sampled on the falling edge.
    always @(negedge clk) begin
        if (step_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge and settle 2 ns past it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One tick pulse: high for hi cycles, low for lo cycles; exp is the pattern
    // that must appear one cycle after tick_in is first sampled high.
    task automatic step_tick(input logic [5:0] exp, input int hi, input int lo);
        logic [5:0] e;
        @(negedge clk);
        tick_in = 1'b1;
        sb_q.push_back(exp);
        cyc();
        e = sb_q.pop_front();
        check("strobe_on_step", {5'd0, step_strobe}, 6'd1);
        check("led_after_step", led, ~e);
        for (int k = 1; k < hi; k++) begin
            cyc();
            check("strobe_held_high", {5'd0, step_strobe}, 6'd0);
        end
        @(negedge clk);
        tick_in = 1'b0;
        for (int k = 0; k < lo; k++) begin
            cyc();
            check("strobe_tick_low", {5'd0, step_strobe}, 6'd0);
        end
        check("led_hold", led, ~e);
    endtask

    // Full press (10 cycles low) then release (8 cycles high).
    task automatic press_btn(input logic [1:0] exp_mode, input logic [5:0] exp_led);
        @(negedge clk);
        mode_btn = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("press_mode", {4'd0, mode}, {4'd0, exp_mode});
        check("press_led", led, exp_led);
        @(negedge clk);
        mode_btn = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("release_mode", {4'd0, mode}, {4'd0, exp_mode});
    endtask

    initial begin
        // Reset with tick_in toggling; last reset edge samples tick_in=1.
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("reset_led", led, 6'h3F);
            check("reset_mode", {4'd0, mode}, 6'd0);
            check("reset_no_step", {5'd0, step_strobe}, 6'd0);
        end
        @(negedge clk); tick_in = 1'b0;
        cyc();
        cyc();
        check("reset_led_after_fall", led, 6'h3F);

        // COUNT: 65 ticks, pattern 1..63, 0, 1.
        c0 = strobe_cnt;
        for (int i = 1; i <= 65; i++) begin
            logic [6:0] iv;
            iv = 7'(i);
            step_tick(iv[5:0], 5, 2);
        end
        check_cnt("count_strobes", strobe_cnt - c0, 65);
        step_tick(6'h02, 2, 2);

        // Debounce: a 2-cycle glitch is rejected.
        @(negedge clk); mode_btn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); mode_btn = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("glitch_mode", {4'd0, mode}, 6'd0);
        check("glitch_led", led, 6'h3D);

        // Debounce: held press accepted on the 6th edge counting the first low sample.
        @(negedge clk); mode_btn = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("debounce_mode_early", {4'd0, mode}, 6'd0);
        cyc();
        check("debounce_mode_accept", {4'd0, mode}, 6'd1);
        check("debounce_seed_led", led, 6'h3E);
        check("debounce_no_strobe", {5'd0, step_strobe}, 6'd0);
        repeat (4) @(posedge clk);
        @(negedge clk); mode_btn = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        check("release_no_change", {4'd0, mode}, 6'd1);

        // WALK including wrap from 6'h20 to 6'h01.
        for (int i = 0; i < 6; i++) step_tick(walk_tbl[i], 3, 2);

        // BOUNCE.
        press_btn(2'd2, 6'h3E);
        for (int i = 0; i < 12; i++) step_tick(bounce_tbl[i], 3, 2);

        // BLINK.
        press_btn(2'd3, 6'h3F);
        step_tick(6'h3F, 3, 2);
        check("blink_on", led, 6'h00);
        step_tick(6'h00, 3, 2);

        // Back to COUNT and advance to 6'h05.
        press_btn(2'd0, 6'h3F);
        for (int i = 1; i <= 5; i++) begin
            logic [5:0] iv;
            iv = 6'(i);
            step_tick(iv, 2, 2);
        end

        // Collision: press acceptance and tick edge on the same clock edge.
        @(negedge clk); mode_btn = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("collide_pre_mode", {4'd0, mode}, 6'd0);
        check("collide_pre_led", led, 6'h3A);
        @(negedge clk); tick_in = 1'b1;
        cyc();
        check("collide_mode", {4'd0, mode}, 6'd1);
        check("collide_led", led, 6'h3E);
        check("collide_no_strobe", {5'd0, step_strobe}, 6'd0);
        cyc();
        check("collide_step_dropped", {5'd0, step_strobe}, 6'd0);
        check("collide_led_hold", led, 6'h3E);
        @(negedge clk); mode_btn = 1'b1; tick_in = 1'b0;
        repeat (8) @(posedge clk);

        // Reset in the middle of BLINK.
        press_btn(2'd2, 6'h3E);
        press_btn(2'd3, 6'h3F);
        step_tick(6'h3F, 2, 2);
        @(negedge clk); rst_n = 1'b0;
        cyc();
        check("midreset_led", led, 6'h3F);
        check("midreset_mode", {4'd0, mode}, 6'd0);
        check("midreset_strobe", {5'd0, step_strobe}, 6'd0);
        @(negedge clk); rst_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
